snoopy_motion: RTL and testbench

Player-sprite motion controller for the runner game. Produces the 4x4 sprite's top-left coordinate (`x_c`, `y_c`) each frame, applying constant horizontal scrolling and a button-triggered jump arc. It consumes the `collided` and `reached_screen_end` flags that `collision_end` derives from those same coordinates, freezing the sprite on a hit or on reaching the goal. Sits between the input/frame-timing logic and both the collision checker and the VGA redraw FSM.

---
 rtl/snoopy_motion_pkg.sv | 29 ++
 rtl/snoopy_motion_jump_ctrl.sv | 86 ++++++++
 rtl/snoopy_motion.sv | 107 ++++++++++
 tb/tb_snoopy_motion.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/snoopy_motion_pkg.sv
// Shared state encodings and default playfield geometry for the runner sprite
// motion controller and its collision checker.
package motion_pkg;

  typedef enum logic [1:0] {
    G_IDLE = 2'd0,
    G_RUN  = 2'd1,
    G_DEAD = 2'd2,
    G_WIN  = 2'd3
  } game_state_t;

  typedef enum logic [1:0] {
    A_GROUND = 2'd0,
    A_RISE   = 2'd1,
    A_HOVER  = 2'd2,
    A_FALL   = 2'd3
  } air_state_t;

  localparam logic [7:0] X_START_DEF     = 8'd0;
  localparam logic [6:0] GROUND_Y_DEF    = 7'd100;
  localparam int         JUMP_HEIGHT_DEF = 16;
  localparam int         HOVER_TICKS_DEF = 4;
  localparam int         X_DIV_DEF       = 2;
  localparam logic [7:0] X_MAX_DEF       = 8'd156;
  localparam int         SPRITE_SIZE     = 4;
  localparam int         SCREEN_W        = 160;
  localparam int         SCREEN_H        = 120;

endpackage

// File: rtl/snoopy_motion_jump_ctrl.sv
// Vertical motion: air FSM, apex hover counter and the one-deep jump request.
// y_moved is combinational and flags that y_c changes at the coming clock edge.
module jump_ctrl
  import motion_pkg::*;
#(
  parameter logic [6:0] GROUND_Y    = GROUND_Y_DEF,
  parameter int         JUMP_HEIGHT = JUMP_HEIGHT_DEF,
  parameter int         HOVER_TICKS = HOVER_TICKS_DEF
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       tick_en,
  input  logic       jump_rise,
  output logic [6:0] y_c,
  output logic       y_moved
);

  localparam logic [6:0] TOP_Y      = GROUND_Y - 7'(JUMP_HEIGHT);
  localparam int         HW         = (HOVER_TICKS > 1) ? $clog2(HOVER_TICKS) : 1;
  localparam logic [HW-1:0] HOVER_LAST = HW'(HOVER_TICKS - 1);

  air_state_t    r_air, w_air_nxt;
  logic [6:0]    r_y, w_y_nxt;
  logic [HW-1:0] r_hov, w_hov_nxt;
  logic          r_pending, w_pend_nxt;
  logic [6:0]    w_y_dec, w_y_inc;

  assign w_y_dec = r_y - 7'd1;
  assign w_y_inc = r_y + 7'd1;
  assign y_c     = r_y;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_air     <= A_GROUND;
      r_y       <= GROUND_Y;
      r_hov     <= '0;
      r_pending <= 1'b0;
    end else begin
      r_air     <= w_air_nxt;
      r_y       <= w_y_nxt;
      r_hov     <= w_hov_nxt;
      r_pending <= w_pend_nxt;
    end
  end

  always_comb begin
    w_air_nxt  = r_air;
    w_y_nxt    = r_y;
    w_hov_nxt  = r_hov;
    w_pend_nxt = r_pending;
    y_moved    = 1'b0;
    // Requests only register on the ground; airborne presses are dropped, not queued.
    if (jump_rise && (r_air == A_GROUND)) w_pend_nxt = 1'b1;
    if (tick_en) begin
      case (r_air)
        A_GROUND: begin
          if (r_pending) begin
            w_pend_nxt = 1'b0;
            w_y_nxt    = w_y_dec;
            y_moved    = 1'b1;
            w_hov_nxt  = '0;
            w_air_nxt  = (w_y_dec == TOP_Y) ? A_HOVER : A_RISE;
          end
        end
        A_RISE: begin
          w_y_nxt = w_y_dec;
          y_moved = 1'b1;
          if (w_y_dec == TOP_Y) begin
            w_air_nxt = A_HOVER;
            w_hov_nxt = '0;
          end
        end
        A_HOVER: begin
          if (r_hov == HOVER_LAST) w_air_nxt = A_FALL;
          else                     w_hov_nxt = r_hov + 1'b1;
        end
        default: begin
          w_y_nxt = w_y_inc;
          y_moved = 1'b1;
          if (w_y_inc == GROUND_Y) w_air_nxt = A_GROUND;
        end
      endcase
    end
  end

endmodule

// File: rtl/snoopy_motion.sv
// Runner sprite motion: game FSM, horizontal scroll divider and erase bookkeeping
// around the jump controller. Coordinates update the cycle after frame_tick.
module snoopy_motion
  import motion_pkg::*;
#(
  parameter logic [7:0] X_START     = X_START_DEF,
  parameter logic [6:0] GROUND_Y    = GROUND_Y_DEF,
  parameter int         JUMP_HEIGHT = JUMP_HEIGHT_DEF,
  parameter int         HOVER_TICKS = HOVER_TICKS_DEF,
  parameter int         X_DIV       = X_DIV_DEF,
  parameter logic [7:0] X_MAX       = X_MAX_DEF
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       start,
  input  logic       jump,
  input  logic       collided,
  input  logic       reached_screen_end,
  output logic [7:0] x_c,
  output logic [6:0] y_c,
  output logic [7:0] x_prev,
  output logic [6:0] y_prev,
  output logic       moved,
  output logic       running,
  output logic       dead,
  output logic       won
);

  localparam int             DW       = (X_DIV > 1) ? $clog2(X_DIV) : 1;
  localparam logic [DW-1:0]  DIV_LAST = DW'(X_DIV - 1);

  game_state_t   r_game, w_game_nxt;
  logic [DW-1:0] r_div;
  logic [7:0]    r_x, r_x_prev;
  logic [6:0]    r_y_prev;
  logic          r_moved, r_jump_d;
  logic          w_tick_en, w_jump_rise, w_div_wrap, w_x_step, w_y_moved, w_any_move;
  logic [6:0]    w_y;

  // Flags win over the tick: a hit or goal in the tick cycle freezes without moving.
  assign w_tick_en   = frame_tick && (r_game == G_RUN) && !collided && !reached_screen_end;
  assign w_jump_rise = jump && !r_jump_d && (r_game == G_RUN);
  assign w_div_wrap  = w_tick_en && (r_div == DIV_LAST);
  assign w_x_step    = w_div_wrap && (r_x < X_MAX);
  assign w_any_move  = w_x_step || w_y_moved;

  jump_ctrl #(
    .GROUND_Y    (GROUND_Y),
    .JUMP_HEIGHT (JUMP_HEIGHT),
    .HOVER_TICKS (HOVER_TICKS)
  ) u_jump (
    .clock     (clock),
    .reset     (reset),
    .tick_en   (w_tick_en),
    .jump_rise (w_jump_rise),
    .y_c       (w_y),
    .y_moved   (w_y_moved)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_game <= G_IDLE;
    else       r_game <= w_game_nxt;
  end

  always_comb begin
    w_game_nxt = r_game;
    case (r_game)
      G_IDLE: if (start) w_game_nxt = G_RUN;
      G_RUN: begin
        if (collided)                w_game_nxt = G_DEAD;
        else if (reached_screen_end) w_game_nxt = G_WIN;
      end
      default: w_game_nxt = r_game;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_div    <= '0;
      r_x      <= X_START;
      r_x_prev <= X_START;
      r_y_prev <= GROUND_Y;
      r_moved  <= 1'b0;
      r_jump_d <= 1'b0;
    end else begin
      r_jump_d <= jump;
      r_moved  <= w_any_move;
      if (w_tick_en) r_div <= w_div_wrap ? '0 : r_div + 1'b1;
      if (w_x_step)  r_x   <= r_x + 8'd1;
      if (w_any_move) begin
        r_x_prev <= r_x;
        r_y_prev <= w_y;
      end
    end
  end

  assign x_c     = r_x;
  assign y_c     = w_y;
  assign x_prev  = r_x_prev;
  assign y_prev  = r_y_prev;
  assign moved   = r_moved;
  assign running = (r_game == G_RUN);
  assign dead    = (r_game == G_DEAD);
  assign won     = (r_game == G_WIN);

endmodule

// File: tb/tb_snoopy_motion.sv
// Directed bench for snoopy_motion: a table of tick phases with hand-derived
// coordinates, then hand-written sequences for flags, saturation and reset.
module tb_snoopy_motion;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       frame_tick = 1'b0;
  logic       start = 1'b0;
  logic       jump = 1'b0;
  logic       collided = 1'b0;
  logic       reached_screen_end = 1'b0;
  logic [7:0] x_c, x_prev;
  logic [6:0] y_c, y_prev;
  logic       moved, running, dead, won;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  snoopy_motion dut (
    .clock              (clock),
    .reset              (reset),
    .frame_tick         (frame_tick),
    .start              (start),
    .jump               (jump),
    .collided           (collided),
    .reached_screen_end (reached_screen_end),
    .x_c                (x_c),
    .y_c                (y_c),
    .x_prev             (x_prev),
    .y_prev             (y_prev),
    .moved              (moved),
    .running            (running),
    .dead               (dead),
    .won                (won)
  );

  typedef struct {
    int         ticks;
    logic       strt;
    logic       jmp;
    logic [7:0] ex;
    logic [6:0] ey;
    int         emv;
    logic [7:0] epx;
    logic [6:0] epy;
    logic       erun;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Each tick is a one-cycle pulse followed by three idle cycles; moved is
  // sampled in both following cycles so a stuck pulse is counted twice.
  task automatic run_ticks(input int n, output int nmoved);
    nmoved = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clock); frame_tick = 1'b1;
      @(negedge clock); frame_tick = 1'b0;
      if (moved) nmoved++;
      @(negedge clock);
      if (moved) nmoved++;
      @(negedge clock);
    end
  endtask

  task automatic pulse_start();
    @(negedge clock); start = 1'b1;
    @(negedge clock); start = 1'b0;
  endtask

  task automatic pulse_jump();
    @(negedge clock); jump = 1'b1;
    @(negedge clock); jump = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1; collided = 1'b0; reached_screen_end = 1'b0;
    start = 1'b0; jump = 1'b0; frame_tick = 1'b0;
    @(negedge clock); @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
  endtask

  initial begin
    int nm;
    //          ticks strt jmp  x      y       mv  xprev  yprev   run
    vecs[0] = '{10, 1'b0, 1'b0, 8'd0,  7'd100, 0,  8'd0,  7'd100, 1'b0};
    vecs[1] = '{10, 1'b1, 1'b0, 8'd5,  7'd100, 5,  8'd4,  7'd100, 1'b1};
    vecs[2] = '{30, 1'b0, 1'b0, 8'd20, 7'd100, 15, 8'd19, 7'd100, 1'b1};
    vecs[3] = '{16, 1'b0, 1'b1, 8'd28, 7'd84,  16, 8'd27, 7'd85,  1'b1};
    vecs[4] = '{4,  1'b0, 1'b1, 8'd30, 7'd84,  2,  8'd29, 7'd84,  1'b1};
    vecs[5] = '{16, 1'b0, 1'b0, 8'd38, 7'd100, 16, 8'd37, 7'd99,  1'b1};

    @(negedge clock);
    chk("reset_x", x_c, 0);
    chk("reset_y", y_c, 100);
    chk("reset_moved", moved, 0);
    chk("reset_state", {running, dead, won}, 0);
    @(negedge clock); reset = 1'b0;
    @(negedge clock);

    for (int v = 0; v < 6; v++) begin
      if (vecs[v].strt) pulse_start();
      if (vecs[v].jmp)  pulse_jump();
      run_ticks(vecs[v].ticks, nm);
      chk($sformatf("vec%0d_x", v), x_c, vecs[v].ex);
      chk($sformatf("vec%0d_y", v), y_c, vecs[v].ey);
      chk($sformatf("vec%0d_moved_count", v), nm, vecs[v].emv);
      chk($sformatf("vec%0d_x_prev", v), x_prev, vecs[v].epx);
      chk($sformatf("vec%0d_y_prev", v), y_prev, vecs[v].epy);
      chk($sformatf("vec%0d_running", v), running, vecs[v].erun);
    end

    // Saturation: 118 more steps from 38 reach 156, then x holds.
    run_ticks(236, nm);
    chk("sat_x_reach", x_c, 156);
    run_ticks(6, nm);
    chk("sat_x_hold", x_c, 156);
    chk("sat_no_moved", nm, 0);
    @(negedge clock); reached_screen_end = 1'b1;
    @(negedge clock);
    chk("win_won", won, 1);
    chk("win_dead", dead, 0);
    chk("win_running", running, 0);
    collided = 1'b1;
    run_ticks(3, nm);
    chk("win_terminal", {dead, won}, 1);
    chk("win_frozen_moves", nm, 0);

    // Hit and goal together with the tick: collided wins and nothing moves.
    do_reset();
    pulse_start();
    run_ticks(4, nm);
    chk("hit_pre_x", x_c, 2);
    @(negedge clock);
    collided = 1'b1; reached_screen_end = 1'b1; frame_tick = 1'b1;
    @(negedge clock);
    frame_tick = 1'b0;
    chk("hit_dead", dead, 1);
    chk("hit_won", won, 0);
    chk("hit_moved", moved, 0);
    chk("hit_x", x_c, 2);
    start = 1'b1;
    pulse_jump();
    run_ticks(5, nm);
    start = 1'b0;
    chk("dead_x_frozen", x_c, 2);
    chk("dead_y_frozen", y_c, 100);
    chk("dead_no_moves", nm, 0);
    chk("dead_start_ignored", {running, dead}, 1);

    // Reset mid-rise clears everything asynchronously.
    do_reset();
    pulse_start();
    pulse_jump();
    run_ticks(10, nm);
    chk("rise_y90", y_c, 90);
    #2 reset = 1'b1;
    #1;
    chk("async_x", x_c, 0);
    chk("async_y", y_c, 100);
    chk("async_prev", {x_prev, 1'b0, y_prev}, {8'd0, 1'b0, 7'd100});
    chk("async_state", {running, dead, won, moved}, 0);
    @(negedge clock); @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    pulse_jump();
    pulse_start();
    run_ticks(2, nm);
    chk("idle_jump_not_queued", y_c, 100);
    pulse_jump();
    run_ticks(16, nm);
    chk("rejump_apex", y_c, 84);
    chk("rejump_moves", nm, 16);
    run_ticks(4, nm);
    chk("rejump_hover", y_c, 84);
    run_ticks(16, nm);
    chk("rejump_land", y_c, 100);
    chk("rejump_x", x_c, 19);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
